// File: rtl/seq_lock_ctrl.sv
// seq_lock_ctrl: collects CODE_LEN 3-bit symbols, compares them with a preset
// code and drives unlock / err / alarm indications with retry counting, entry
// timeout and lockout.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_sym_valid  one-cycle strobe, symbol committed
//   i_sym_data   symbol value, sampled with i_sym_valid
//   i_clr        one-cycle strobe, abort current entry
//   o_unlock     code accepted, held OPEN_CYC cycles
//   o_err        wrong code, held ERR_CYC cycles
//   o_alarm      lockout active, held LOCK_CYC cycles
//   o_busy       high in every state except idle
//   o_entry_cnt  symbols accepted in the current attempt
//   o_fail_cnt   consecutive failed attempts
module seq_lock_ctrl #(
  parameter int unsigned CODE_LEN    = 4,
  parameter logic [23:0] CODE        = 24'o00005273,
  parameter int unsigned MAX_TRY     = 3,
  parameter int unsigned OPEN_CYC    = 50_000_000,
  parameter int unsigned ERR_CYC     = 25_000_000,
  parameter int unsigned LOCK_CYC    = 250_000_000,
  parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sym_valid,
  input  logic [2:0] i_sym_data,
  input  logic       i_clr,
  output logic       o_unlock,
  output logic       o_err,
  output logic       o_alarm,
  output logic       o_busy,
  output logic [3:0] o_entry_cnt,
  output logic [2:0] o_fail_cnt
);

  localparam int unsigned    BufW        = 3 * CODE_LEN;
  localparam logic [BufW-1:0] CodeVal    = CODE[BufW-1:0];
  localparam logic [3:0]     CodeLen     = 4'(CODE_LEN);
  localparam logic [2:0]     MaxTry      = 3'(MAX_TRY);
  // Timer values on the last cycle of each timed state.
  localparam logic [27:0]    OpenLast    = 28'(OPEN_CYC - 1);
  localparam logic [27:0]    ErrLast     = 28'(ERR_CYC - 1);
  localparam logic [27:0]    LockLast    = 28'(LOCK_CYC - 1);
  localparam logic [27:0]    TimeoutLast = 28'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheck,
    StOpen,
    StError,
    StLockout
  } state_e;

  state_e          r_state, w_state_d;
  logic [27:0]     r_timer, w_timer_d;
  logic [3:0]      r_entry_cnt, w_entry_cnt_d;
  logic [2:0]      r_fail_cnt, w_fail_cnt_d;
  logic [BufW-1:0] r_buf, w_buf_d;
  logic            w_accept;

  always_comb begin
    w_state_d     = r_state;
    w_entry_cnt_d = r_entry_cnt;
    w_fail_cnt_d  = r_fail_cnt;
    w_buf_d       = r_buf;
    w_accept      = 1'b0;

    case (r_state)
      StIdle: begin
        // clr wins over a simultaneous symbol.
        if (i_sym_valid && !i_clr) begin
          w_accept  = 1'b1;
          w_state_d = (CodeLen == 4'd1) ? StCheck : StEntry;
        end
      end
      StEntry: begin
        if (i_clr || (!i_sym_valid && r_timer == TimeoutLast)) begin
          w_state_d     = StIdle;
          w_entry_cnt_d = '0;
          w_buf_d       = '0;
        end else if (i_sym_valid && r_entry_cnt < CodeLen) begin
          w_accept = 1'b1;
          if (r_entry_cnt + 4'd1 == CodeLen) begin
            w_state_d = StCheck;
          end
        end
      end
      StCheck: begin
        w_entry_cnt_d = '0;
        w_buf_d       = '0;
        if (r_buf == CodeVal) begin
          w_fail_cnt_d = '0;
          w_state_d    = StOpen;
        end else if (r_fail_cnt + 3'd1 == MaxTry) begin
          w_fail_cnt_d = MaxTry;
          w_state_d    = StLockout;
        end else begin
          w_fail_cnt_d = r_fail_cnt + 3'd1;
          w_state_d    = StError;
        end
      end
      StOpen: begin
        if (i_clr || r_timer == OpenLast) begin
          w_state_d = StIdle;
        end
      end
      StError: begin
        if (i_clr || r_timer == ErrLast) begin
          w_state_d = StIdle;
        end
      end
      StLockout: begin
        if (r_timer == LockLast) begin
          w_fail_cnt_d = '0;
          w_state_d    = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Slot 0 lives in the most significant symbol position.
    if (w_accept) begin
      for (int unsigned k = 0; k < CODE_LEN; k++) begin
        if (r_entry_cnt == 4'(k)) begin
          w_buf_d[BufW-1-3*k -: 3] = i_sym_data;
        end
      end
      w_entry_cnt_d = r_entry_cnt + 4'd1;
    end

    // Shared timer restarts on any state change or accepted symbol.
    if (w_state_d != r_state || w_accept) begin
      w_timer_d = '0;
    end else begin
      w_timer_d = r_timer + 28'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_timer     <= '0;
      r_entry_cnt <= '0;
      r_fail_cnt  <= '0;
      r_buf       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_timer     <= w_timer_d;
      r_entry_cnt <= w_entry_cnt_d;
      r_fail_cnt  <= w_fail_cnt_d;
      r_buf       <= w_buf_d;
    end
  end

  assign o_unlock    = (r_state == StOpen);
  assign o_err       = (r_state == StError);
  assign o_alarm     = (r_state == StLockout);
  assign o_busy      = (r_state != StIdle);
  assign o_entry_cnt = r_entry_cnt;
  assign o_fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// Directed bench for seq_lock_ctrl with short timing parameters.
module tb_seq_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_sym_valid = 1'b0;
  logic [2:0] i_sym_data = 3'd0;
  logic       i_clr = 1'b0;
  logic       o_unlock, o_err, o_alarm, o_busy;
  logic [3:0] o_entry_cnt;
  logic [2:0] o_fail_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int len;

  seq_lock_ctrl #(
    .CODE_LEN   (4),
    .CODE       (24'o5273),
    .MAX_TRY    (3),
    .OPEN_CYC   (8),
    .ERR_CYC    (4),
    .LOCK_CYC   (16),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sym_valid(i_sym_valid),
    .i_sym_data (i_sym_data),
    .i_clr      (i_clr),
    .o_unlock   (o_unlock),
    .o_err      (o_err),
    .o_alarm    (o_alarm),
    .o_busy     (o_busy),
    .o_entry_cnt(o_entry_cnt),
    .o_fail_cnt (o_fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [2:0] s);
    i_sym_valid = 1'b1;
    i_sym_data  = s;
    step();
    i_sym_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
  endtask

  task automatic send_code(input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [2:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return o_unlock;
      1:       return o_err;
      default: return o_alarm;
    endcase
  endfunction

  // Counts cycles (including the current one) for which the selected output stays high.
  task automatic measure(input int sel, output int n);
    n = 0;
    while (sel_sig(sel) && n < 100) begin
      n++;
      step();
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_unlock", o_unlock, 0);
    chk("rst_err", o_err, 0);
    chk("rst_alarm", o_alarm, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_entry", o_entry_cnt, 0);
    chk("rst_fail", o_fail_cnt, 0);
    rst_n = 1'b1;
    step();

    // Correct code with 3-cycle gaps
    send(3'd5);
    chk("ok_entry1", o_entry_cnt, 1);
    chk("ok_busy1", o_busy, 1);
    idle(3);
    send(3'd2);
    idle(3);
    send(3'd7);
    chk("ok_entry3", o_entry_cnt, 3);
    idle(3);
    send(3'd3);
    chk("ok_check_unlock", o_unlock, 0);
    chk("ok_check_busy", o_busy, 1);
    chk("ok_check_entry", o_entry_cnt, 4);
    step();
    chk("ok_unlock", o_unlock, 1);
    chk("ok_entry0", o_entry_cnt, 0);
    chk("ok_fail0", o_fail_cnt, 0);
    measure(0, len);
    chk("ok_unlock_len", len, 8);
    chk("ok_busy_after", o_busy, 0);

    // Wrong code, then correct code
    send_code(3'd5, 3'd2, 3'd7, 3'd4);
    step();
    chk("bad_err", o_err, 1);
    chk("bad_unlock", o_unlock, 0);
    chk("bad_fail1", o_fail_cnt, 1);
    measure(1, len);
    chk("bad_err_len", len, 4);
    chk("bad_busy_after", o_busy, 0);
    send_code(3'd5, 3'd2, 3'd7, 3'd3);
    step();
    chk("retry_unlock", o_unlock, 1);
    chk("retry_fail0", o_fail_cnt, 0);
    measure(0, len);
    chk("retry_unlock_len", len, 8);

    // Three wrong codes -> lockout
    send_code(3'd1, 3'd1, 3'd1, 3'd1);
    step();
    chk("lk_fail1", o_fail_cnt, 1);
    measure(1, len);
    send_code(3'd3, 3'd7, 3'd2, 3'd5);
    step();
    chk("lk_fail2", o_fail_cnt, 2);
    measure(1, len);
    send_code(3'd5, 3'd2, 3'd7, 3'd0);
    step();
    chk("lk_alarm", o_alarm, 1);
    chk("lk_err", o_err, 0);
    chk("lk_fail3", o_fail_cnt, 3);
    send(3'd5);
    chk("lk_ignore_sym", o_entry_cnt, 0);
    pulse_clr();
    chk("lk_ignore_clr", o_alarm, 1);
    send(3'd2);
    chk("lk_ignore_sym2", o_entry_cnt, 0);
    measure(2, len);
    chk("lk_alarm_rest", len, 13);
    chk("lk_fail_cleared", o_fail_cnt, 0);
    chk("lk_busy_after", o_busy, 0);
    send_code(3'd5, 3'd2, 3'd7, 3'd3);
    step();
    chk("lk_unlock_after", o_unlock, 1);
    measure(0, len);

    // Timeout keeps fail count
    send_code(3'd6, 3'd2, 3'd7, 3'd3);
    step();
    measure(1, len);
    chk("to_fail1", o_fail_cnt, 1);
    send(3'd5);
    send(3'd2);
    idle(19);
    chk("to_busy_pre", o_busy, 1);
    chk("to_entry_pre", o_entry_cnt, 2);
    step();
    chk("to_busy", o_busy, 0);
    chk("to_entry", o_entry_cnt, 0);
    chk("to_fail", o_fail_cnt, 1);

    // Abort with clr
    send(3'd5);
    pulse_clr();
    chk("clr_busy", o_busy, 0);
    chk("clr_entry", o_entry_cnt, 0);
    chk("clr_fail", o_fail_cnt, 1);

    // Simultaneous sym_valid and clr
    i_sym_valid = 1'b1;
    i_sym_data  = 3'd5;
    i_clr       = 1'b1;
    step();
    i_sym_valid = 1'b0;
    i_clr       = 1'b0;
    chk("sim_idle_entry", o_entry_cnt, 0);
    chk("sim_idle_busy", o_busy, 0);
    send(3'd5);
    i_sym_valid = 1'b1;
    i_sym_data  = 3'd2;
    i_clr       = 1'b1;
    step();
    i_sym_valid = 1'b0;
    i_clr       = 1'b0;
    chk("sim_entry_entry", o_entry_cnt, 0);
    chk("sim_entry_busy", o_busy, 0);
    send_code(3'd5, 3'd2, 3'd7, 3'd3);
    step();
    chk("sim_unlock", o_unlock, 1);
    chk("sim_fail0", o_fail_cnt, 0);
    measure(0, len);
    chk("sim_unlock_len", len, 8);

    // Async reset during error (fail count lost)
    send_code(3'd0, 3'd0, 3'd0, 3'd0);
    step();
    chk("ar_err_pre", o_err, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_err", o_err, 0);
    chk("ar_fail_err", o_fail_cnt, 0);
    rst_n = 1'b1;
    step();

    // Async reset at cycle 3 of unlock
    send_code(3'd5, 3'd2, 3'd7, 3'd3);
    step();
    idle(2);
    chk("ar_unlock_pre", o_unlock, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_unlock", o_unlock, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_fail", o_fail_cnt, 0);
    rst_n = 1'b1;
    step();
    send_code(3'd5, 3'd2, 3'd7, 3'd3);
    step();
    chk("ar_fresh_unlock", o_unlock, 1);
    measure(0, len);
    chk("ar_fresh_len", len, 8);
    chk("ar_fresh_busy", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
